// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - memory read bus and instruction hand-off bundle for the prefetch queue
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 16
);
    // Synchronous RAM read port: data for a request appears one cycle later
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_data_in;

    // Flush and restart request from the branch unit
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // Decoded head instruction offered to the execute stage
    logic              ie_ready;
    logic              instr_valid;
    logic [7:0]        opcode;
    logic [15:0]       operand;
    logic [1:0]        instr_len;
    logic [ADDR_W-1:0] instr_pc;

    // Prefetch queue side
    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_data_in,
        input  redirect,
        input  redirect_pc,
        input  ie_ready,
        output instr_valid,
        output opcode,
        output operand,
        output instr_len,
        output instr_pc
    );

    // Memory / consumer / redirect source side
    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_data_in,
        output redirect,
        output redirect_pc,
        output ie_ready,
        input  instr_valid,
        input  opcode,
        input  operand,
        input  instr_len,
        input  instr_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - 6502 byte prefetch queue with length decode; IF_PREFETCH_STATS_EN adds fetch/stall counters
module instr_prefetch_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_prefetch_queue_if.master   bus,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef IF_PREFETCH_STATS_EN
    ,
    output logic [15:0]              fetch_count,
    output logic [15:0]              stall_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LVL_W-1:0]   level;
    logic               rd_pend;     // a read was issued last cycle; its byte is on mem_data_in now
    logic [7:0]         fifo_mem [DEPTH];

    logic               rd_en;
    logic               has_room;
    logic               push;
    logic               hs;
    logic [7:0]         head_byte;
    logic [7:0]         byte1;
    logic [7:0]         byte2;
    logic [1:0]         head_len;
    logic               valid;

    // Instruction length from the NMOS 6502 documented opcode map; anything undocumented is 1
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        casez (op)
            // absolute, absolute indexed, indirect, JSR
            8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'hBC,
            8'h0D, 8'h1D, 8'h2D, 8'h3D, 8'h4D, 8'h5D, 8'h6D, 8'h7D,
            8'h8D, 8'h9D, 8'hAD, 8'hBD, 8'hCD, 8'hDD, 8'hED, 8'hFD,
            8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9,
            8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
            8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE:
                len = 2'd3;
            // (zp,X), (zp),Y, zp and zp indexed of the ALU group
            8'h?1, 8'h?5:
                len = 2'd2;
            // immediate
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
            8'hA0, 8'hA2, 8'hC0, 8'hE0:
                len = 2'd2;
            // zero page and zero page indexed of the shift/load/store groups
            8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6,
            8'h16, 8'h36, 8'h56, 8'h76, 8'h96, 8'hB6, 8'hD6, 8'hF6,
            8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4, 8'h94, 8'hB4:
                len = 2'd2;
            // relative branches
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
                len = 2'd2;
            default:
                len = 2'd1;
        endcase
        return len;
    endfunction

    // Reads and returning bytes are both counted so an in-flight byte always has a slot
    assign has_room = ({1'b0, level} + (LVL_W + 1)'(rd_pend)) < (LVL_W + 1)'(DEPTH);

    // A redirect kills the byte arriving at the same edge
    assign push = rd_pend && !bus.redirect;

    // Head decode: an empty queue presents opcode 0 (BRK), which decodes as length 1
    assign head_byte = (level != '0) ? fifo_mem[rd_ptr] : 8'h00;
    assign byte1     = fifo_mem[rd_ptr + PTR_W'(1)];
    assign byte2     = fifo_mem[rd_ptr + PTR_W'(2)];
    assign head_len  = op_len(head_byte);
    assign valid     = (level >= LVL_W'(head_len)) && !bus.redirect;
    assign hs        = valid && bus.ie_ready;

    assign bus.mem_addr    = fetch_pc;
    assign bus.mem_rd_en   = rd_en;
    assign bus.instr_valid = valid;
    assign bus.opcode      = head_byte;
    assign bus.operand     = {(head_len == 2'd3) ? byte2 : 8'h00,
                              (head_len >= 2'd2) ? byte1 : 8'h00};
    assign bus.instr_len   = head_len;
    assign bus.instr_pc    = instr_pc_q;
    assign fifo_level      = level;

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state and read request; no read is issued during a redirect cycle
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = FETCH;
                rd_en   = !bus.redirect && has_room;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte storage; contents never need reset because level gates every use
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_data_in;
        end
    end

    // Pointers, level, program counters and the in-flight read flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= '0;
            instr_pc_q <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            rd_pend    <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc   <= bus.redirect_pc;
            instr_pc_q <= bus.redirect_pc;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (hs) begin
                rd_ptr     <= rd_ptr + PTR_W'(head_len);
                instr_pc_q <= instr_pc_q + ADDR_W'(head_len);
            end
            level <= level + LVL_W'(push) - (hs ? LVL_W'(head_len) : '0);
        end
    end

`ifdef IF_PREFETCH_STATS_EN
    // Saturating read and consumer-starvation counters, restarted by redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (bus.redirect) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (rd_en && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (bus.ie_ready && !valid && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - scoreboard bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  fifo_level;
`ifdef IF_PREFETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    logic [7:0]  ram [65536];
    exp_t        exp_q [$];
    int          checks;
    int          errors;

    instr_prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    instr_prefetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level)
`ifdef IF_PREFETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM model
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_data_in <= ram[bus.mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [15:0] opd,
                            input logic [1:0] len, input logic [15:0] pc);
        exp_t e;
        e.op = op; e.opd = opd; e.len = len; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  bus.mem_rd_en, 0);
        check({tag, "_addr"},   bus.mem_addr, 0);
        check({tag, "_valid"},  bus.instr_valid, 0);
        check({tag, "_opcode"}, bus.opcode, 0);
        check({tag, "_operand"}, bus.operand, 0);
        check({tag, "_len"},    bus.instr_len, 1);
        check({tag, "_pc"},     bus.instr_pc, 0);
        check({tag, "_level"},  fifo_level, 0);
    endtask

    // called at posedge+1; returns at posedge+1 just after the redirect edge E0
    task automatic do_redirect(input logic [15:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.redirect    = 1'b0;
    endtask

    // consume n instructions with ie_ready high, comparing each against the scoreboard
    task automatic drain(input int n);
        int   got;
        int   budget;
        exp_t e;
        got    = 0;
        budget = 0;
        bus.ie_ready = 1'b1;
        while (got < n && budget < 60) begin
            @(negedge clk);
            if (bus.instr_valid && bus.ie_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("opcode",    bus.opcode,    e.op);
                    check("operand",   bus.operand,   e.opd);
                    check("instr_len", bus.instr_len, e.len);
                    check("instr_pc",  bus.instr_pc,  e.pc);
                end
                got++;
            end
            tick();
            budget++;
        end
        bus.ie_ready = 1'b0;
        check("drain_count", got, n);
    endtask

    // measure at which negedge after E0 the head first turns valid
    task automatic redirect_lat(input logic [15:0] pc, input int exp_idx, input string tag);
        int first;
        first = 0;
        do_redirect(pc);
        for (int k = 1; k <= 12 && first == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_first_rd_en"}, bus.mem_rd_en, 1);
                check({tag, "_first_addr"},  bus.mem_addr, pc);
            end
            if (bus.instr_valid) first = k;
        end
        tick();
        check({tag, "_latency"}, first, exp_idx);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ie_ready    = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'hA9; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'hE8;
        ram[16'h0103] = 8'h4C; ram[16'h0104] = 8'h00; ram[16'h0105] = 8'h02;
        for (int i = 16'h0106; i < 16'h0110; i++) ram[i] = 8'hEA;
        ram[16'h0300] = 8'h18;
        ram[16'hFFFE] = 8'h20; ram[16'hFFFF] = 8'h34;
        ram[16'h0000] = 8'h12; ram[16'h0001] = 8'hEA;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("idle_rd_en", bus.mem_rd_en, 0);
        check("idle_level", fifo_level, 0);
        tick();

        // straight-line program at 0x0100
        push_exp(8'hA9, 16'h0005, 2'd2, 16'h0100);
        push_exp(8'hE8, 16'h0000, 2'd1, 16'h0102);
        push_exp(8'h4C, 16'h0200, 2'd3, 16'h0103);
        do_redirect(16'h0100);
        drain(3);

        // consumer stalled: queue fills to DEPTH and fetch stops
        repeat (20) tick();
        @(negedge clk);
        check("full_level",  fifo_level, DEPTH);
        check("full_rd_en",  bus.mem_rd_en, 0);
        check("full_valid",  bus.instr_valid, 1);
        check("full_opcode", bus.opcode, 8'hEA);
        check("full_pc",     bus.instr_pc, 16'h0106);
        tick();
        @(negedge clk);
        check("full_rd_en2",  bus.mem_rd_en, 0);
        check("full_level2",  fifo_level, DEPTH);
        check("full_opcode2", bus.opcode, 8'hEA);
        check("full_pc2",     bus.instr_pc, 16'h0106);
        check("full_len2",    bus.instr_len, 1);
        tick();

        // redirect colliding with a handshake
        bus.ie_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0300;
        @(negedge clk);
        check("hs_void_valid", bus.instr_valid, 0);
        tick();
        bus.redirect = 1'b0;
        bus.ie_ready = 1'b0;
        @(negedge clk);
        check("hs_void_level", fifo_level, 0);
        check("hs_void_pc",    bus.instr_pc, 16'h0300);
        tick();

        // redirect latency for 1-byte and 3-byte heads
        push_exp(8'h18, 16'h0000, 2'd1, 16'h0300);
        redirect_lat(16'h0300, 3, "lat1");
        drain(1);
        push_exp(8'h4C, 16'h0200, 2'd3, 16'h0103);
        redirect_lat(16'h0103, 5, "lat3");
        drain(1);

        // JSR straddling the address wrap
        push_exp(8'h20, 16'h1234, 2'd3, 16'hFFFE);
        push_exp(8'hEA, 16'h0000, 2'd1, 16'h0001);
        do_redirect(16'hFFFE);
        drain(2);

`ifdef IF_PREFETCH_STATS_EN
        // statistics: 5 reads and 3 starved cycles by the sixth negedge after E0
        bus.ie_ready = 1'b1;
        do_redirect(16'h0100);
        repeat (6) @(negedge clk);
        check("fetch_count", fetch_count, 5);
        check("stall_count", stall_count, 3);
        tick();
        bus.ie_ready = 1'b0;
`endif

        // reset with a read in flight
        do_redirect(16'h0100);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_level", fifo_level, 0);
        tick();
        bus.ie_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("post_rst_valid", bus.instr_valid, 0);
        check("post_rst_rd_en", bus.mem_rd_en, 0);
        check("sb_leftover", exp_q.size(), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
